// File: rtl/slave_port_if.sv
// Bus bundle between master_port and slave_port: serial handshake plus local memory-style port.
interface slave_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  mode;
    logic                  wr_bus;
    logic                  master_valid;
    logic                  master_ready;
    logic                  rd_bus;
    logic                  slave_valid;
    logic                  slave_ready;
    logic                  ack;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wr_data;
    logic                  s_wr_en;
    logic                  s_rd_en;
    logic [DATA_WIDTH-1:0] s_rd_data;
    logic                  s_rd_valid;

    modport slave (
        input  mode, wr_bus, master_valid, master_ready, s_rd_data, s_rd_valid,
        output rd_bus, slave_valid, slave_ready, ack, s_addr, s_wr_data, s_wr_en, s_rd_en
    );

    modport master (
        output mode, wr_bus, master_valid, master_ready, s_rd_data, s_rd_valid,
        input  rd_bus, slave_valid, slave_ready, ack, s_addr, s_wr_data, s_wr_en, s_rd_en
    );
endinterface

// File: rtl/slave_port.sv
// Serial bus slave: deserialises address/write data LSB-first, does one local
// write or read per frame, serialises read data back, and closes with an ack pulse.
module slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rstn,
    slave_port_if.slave  bus
);
    localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAXW + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA, ACK} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d, s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0] wdat_sh_q, wdat_sh_d, s_wr_data_q, s_wr_data_d;
    logic [DATA_WIDTH-1:0] rd_sh_q, rd_sh_d;

    logic                  ready;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_shifted;
    logic [DATA_WIDTH-1:0] wdat_shifted;

    // New bit enters at the MSB so the first bit received ends up in bit 0.
    assign addr_shifted = (addr_sh_q >> 1) | (ADDR_WIDTH'(bus.wr_bus) << (ADDR_WIDTH - 1));
    assign wdat_shifted = (wdat_sh_q >> 1) | (DATA_WIDTH'(bus.wr_bus) << (DATA_WIDTH - 1));
    assign accept       = bus.master_valid && ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            addr_sh_q   <= '0;
            wdat_sh_q   <= '0;
            rd_sh_q     <= '0;
            s_addr_q    <= '0;
            s_wr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            addr_sh_q   <= addr_sh_d;
            wdat_sh_q   <= wdat_sh_d;
            rd_sh_q     <= rd_sh_d;
            s_addr_q    <= s_addr_d;
            s_wr_data_q <= s_wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        addr_sh_d   = addr_sh_q;
        wdat_sh_d   = wdat_sh_q;
        rd_sh_d     = rd_sh_q;
        s_addr_d    = s_addr_q;
        s_wr_data_d = s_wr_data_q;
        case (state_q)
            IDLE: if (accept) begin
                mode_d    = bus.mode;
                addr_sh_d = addr_shifted;
                if (ADDR_WIDTH == 1) begin
                    s_addr_d = addr_shifted;
                    cnt_d    = '0;
                    state_d  = bus.mode ? WDATA : RREQ;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: if (accept) begin
                addr_sh_d = addr_shifted;
                if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                    s_addr_d = addr_shifted;
                    cnt_d    = '0;
                    state_d  = mode_q ? WDATA : RREQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WDATA: if (accept) begin
                wdat_sh_d = wdat_shifted;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    s_wr_data_d = wdat_shifted;
                    cnt_d       = '0;
                    state_d     = WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: state_d = ACK;
            RREQ:  state_d = RWAIT;
            RWAIT: if (bus.s_rd_valid) begin
                rd_sh_d = bus.s_rd_data;
                cnt_d   = '0;
                state_d = RDATA;
            end
            RDATA: if (bus.master_ready) begin
                rd_sh_d = rd_sh_q >> 1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic sv, rdb, ackp, wen, ren;

    always_comb begin
        ready = 1'b0;
        sv    = 1'b0;
        rdb   = 1'b0;
        ackp  = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        case (state_q)
            IDLE, ADDR, WDATA: ready = 1'b1;
            WRITE:             wen   = 1'b1;
            RREQ:              ren   = 1'b1;
            RDATA: begin
                sv  = 1'b1;
                rdb = rd_sh_q[0];
            end
            ACK:               ackp  = 1'b1;
            default:           ready = 1'b0;
        endcase
    end

    assign bus.slave_ready = ready;
    assign bus.slave_valid = sv;
    assign bus.rd_bus      = rdb;
    assign bus.ack         = ackp;
    assign bus.s_wr_en     = wen;
    assign bus.s_rd_en     = ren;
    assign bus.s_addr      = s_addr_q;
    assign bus.s_wr_data   = s_wr_data_q;
endmodule

// File: tb/tb_slave_port.sv
// Scoreboarded bench for slave_port: frames driven on the falling edge, read bits checked in order.
module tb_slave_port;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    slave_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic exp_q[$];
    logic obs_q[$];

    int wr_en_cyc, wr_en_n, rd_en_cyc, rd_en_n, ack_cyc, ack_n;
    int sv_n, hs_n, hold_viol, rdy_lo_first, rdy_lo_n;
    logic rdy0, timeout;
    logic [AW-1:0] addr_at_ack;
    logic [DW-1:0] wdat_at_ack;

    // Drives one frame from its first bit; cycle k is the k-th rising edge after the frame starts.
    task automatic run_frame(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [DW-1:0] rdat, input int stall_after, input int stall_len,
                             input logic toggle_rdy, input int stop_bits);
        int nbits, b, stall_left, rd_due, ready_ph;
        logic prev_sv, prev_rdy, prev_bus, rdy;
        nbits = AW + (m ? DW : 0);
        b = 0; stall_left = stall_len; rd_due = -1; ready_ph = 0;
        prev_sv = 1'b0; prev_rdy = 1'b1; prev_bus = 1'b0;
        wr_en_cyc = -1; wr_en_n = 0; rd_en_cyc = -1; rd_en_n = 0; ack_cyc = -1; ack_n = 0;
        sv_n = 0; hs_n = 0; hold_viol = 0; rdy_lo_first = -1; rdy_lo_n = 0;
        rdy0 = 1'b0; timeout = 1'b0;
        obs_q.delete();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (stop_bits >= 0 && b == stop_bits) return;
            if (k == 0) rdy0 = bus.slave_ready;
            if (bus.s_wr_en) begin if (wr_en_n == 0) wr_en_cyc = k; wr_en_n++; end
            if (bus.s_rd_en) begin
                if (rd_en_n == 0) begin rd_en_cyc = k; rd_due = k + 3; end
                rd_en_n++;
            end
            if (!bus.slave_ready) begin if (rdy_lo_n == 0) rdy_lo_first = k; rdy_lo_n++; end
            rdy = toggle_rdy ? (ready_ph % 2 == 0) : 1'b1;
            if (bus.slave_valid) begin
                sv_n++;
                if (prev_sv && !prev_rdy && bus.rd_bus !== prev_bus) hold_viol++;
                if (rdy) begin obs_q.push_back(bus.rd_bus); hs_n++; end
                ready_ph++;
            end
            prev_sv = bus.slave_valid; prev_rdy = rdy; prev_bus = bus.rd_bus;
            bus.master_ready = rdy;
            // A stray s_rd_valid at cycle 2 must be ignored outside RWAIT.
            bus.s_rd_valid = (k == rd_due) || (k == 2);
            bus.s_rd_data  = (k == rd_due) ? rdat : DW'($urandom);
            if (bus.ack) begin
                ack_n++; ack_cyc = k;
                addr_at_ack = bus.s_addr; wdat_at_ack = bus.s_wr_data;
                bus.master_valid = 1'b0; bus.wr_bus = 1'($urandom);
                return;
            end
            if (b < nbits && stall_after >= 0 && b == stall_after + 1 && stall_left > 0) begin
                bus.master_valid = 1'b0; bus.wr_bus = 1'($urandom); stall_left--;
            end else if (b < nbits) begin
                bus.master_valid = 1'b1;
                bus.wr_bus = (b < AW) ? a[b] : wd[b-AW];
                bus.mode = (b == 0) ? m : ~m;
                if (bus.slave_ready) b++;
            end else begin
                bus.master_valid = 1'b0; bus.wr_bus = 1'($urandom); bus.mode = 1'($urandom);
            end
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if ({bus.slave_ready, bus.slave_valid, bus.rd_bus, bus.ack, bus.s_wr_en, bus.s_rd_en} !== 6'b100000) begin
            miscompares++; $display("FAIL reset_outs: got %b exp 100000", {bus.slave_ready, bus.slave_valid, bus.rd_bus, bus.ack, bus.s_wr_en, bus.s_rd_en}); end
        vectors++; if (bus.s_addr !== '0 || bus.s_wr_data !== '0) begin
            miscompares++; $display("FAIL reset_regs: got addr %h data %h exp 0", bus.s_addr, bus.s_wr_data); end
        rstn = 1'b1;
    endtask

    task automatic test_write();
        run_frame(1'b1, 12'hABC, 8'hD3, '0, -1, 0, 1'b0, -1);
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL wr_timeout: got %b exp 0", timeout); end
        vectors++; if (addr_at_ack !== 12'hABC) begin miscompares++; $display("FAIL wr_addr: got %h exp abc", addr_at_ack); end
        vectors++; if (wdat_at_ack !== 8'hD3) begin miscompares++; $display("FAIL wr_data: got %h exp d3", wdat_at_ack); end
        vectors++; if (wr_en_cyc !== 20 || wr_en_n !== 1) begin miscompares++; $display("FAIL wr_en: got cyc %0d n %0d exp 20/1", wr_en_cyc, wr_en_n); end
        vectors++; if (ack_cyc !== 21) begin miscompares++; $display("FAIL wr_ack: got %0d exp 21", ack_cyc); end
        vectors++; if (rdy_lo_first !== 20 || rdy_lo_n !== 2) begin miscompares++; $display("FAIL wr_ready_low: got %0d/%0d exp 20/2", rdy_lo_first, rdy_lo_n); end
        vectors++; if (rd_en_n !== 0) begin miscompares++; $display("FAIL wr_no_rd_en: got %0d exp 0", rd_en_n); end
        @(negedge clk);
        vectors++; if ({bus.ack, bus.s_wr_en, bus.slave_ready} !== 3'b001 || bus.s_addr !== 12'hABC) begin
            miscompares++; $display("FAIL wr_after: got %b addr %h exp 001 abc", {bus.ack, bus.s_wr_en, bus.slave_ready}, bus.s_addr); end
    endtask

    task automatic test_read();
        logic [DW-1:0] d;
        logic e, o;
        d = 8'h5A;
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        run_frame(1'b0, 12'h123, '0, d, -1, 0, 1'b0, -1);
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rd_timeout: got %b exp 0", timeout); end
        vectors++; if (rd_en_cyc !== 12 || rd_en_n !== 1) begin miscompares++; $display("FAIL rd_en: got cyc %0d n %0d exp 12/1", rd_en_cyc, rd_en_n); end
        vectors++; if (sv_n !== 8 || hs_n !== 8) begin miscompares++; $display("FAIL rd_valid_cycles: got %0d/%0d exp 8/8", sv_n, hs_n); end
        vectors++; if (ack_cyc !== 24) begin miscompares++; $display("FAIL rd_ack: got %0d exp 24", ack_cyc); end
        vectors++; if (addr_at_ack !== 12'h123 || wr_en_n !== 0) begin miscompares++; $display("FAIL rd_addr: got %h wr %0d exp 123/0", addr_at_ack, wr_en_n); end
        vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rd_bit_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            vectors++; if (o !== e) begin miscompares++; $display("FAIL rd_bit%0d: got %b exp %b", i, o, e); end
        end
        @(negedge clk);
        vectors++; if (bus.ack !== 1'b0) begin miscompares++; $display("FAIL rd_ack_width: got %b exp 0", bus.ack); end
    endtask

    task automatic test_stall();
        run_frame(1'b1, 12'hABC, 8'hD3, '0, 4, 5, 1'b0, -1);
        vectors++; if (addr_at_ack !== 12'hABC || wdat_at_ack !== 8'hD3) begin
            miscompares++; $display("FAIL stall_regs: got %h/%h exp abc/d3", addr_at_ack, wdat_at_ack); end
        vectors++; if (wr_en_cyc !== 25 || wr_en_n !== 1) begin miscompares++; $display("FAIL stall_wr_en: got %0d/%0d exp 25/1", wr_en_cyc, wr_en_n); end
        vectors++; if (ack_cyc !== 26) begin miscompares++; $display("FAIL stall_ack: got %0d exp 26", ack_cyc); end
    endtask

    task automatic test_ready_toggle();
        logic [DW-1:0] d;
        logic e, o;
        d = 8'hA5;
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        run_frame(1'b0, 12'h3E7, '0, d, -1, 0, 1'b1, -1);
        vectors++; if (hs_n !== 8 || sv_n !== 15) begin miscompares++; $display("FAIL tog_handshakes: got %0d/%0d exp 8/15", hs_n, sv_n); end
        vectors++; if (hold_viol !== 0) begin miscompares++; $display("FAIL tog_hold: got %0d exp 0", hold_viol); end
        vectors++; if (ack_cyc !== 31) begin miscompares++; $display("FAIL tog_ack: got %0d exp 31", ack_cyc); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            vectors++; if (o !== e) begin miscompares++; $display("FAIL tog_bit%0d: got %b exp %b", i, o, e); end
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        run_frame(1'b1, 12'h3C5, 8'h77, '0, -1, 0, 1'b0, AW + 5);
        rstn = 1'b0;
        #1;
        vectors++; if ({bus.slave_ready, bus.slave_valid, bus.rd_bus, bus.ack, bus.s_wr_en, bus.s_rd_en} !== 6'b100000) begin
            miscompares++; $display("FAIL abort_outs: got %b exp 100000", {bus.slave_ready, bus.slave_valid, bus.rd_bus, bus.ack, bus.s_wr_en, bus.s_rd_en}); end
        vectors++; if (bus.s_addr !== '0 || bus.s_wr_data !== '0) begin
            miscompares++; $display("FAIL abort_regs: got %h/%h exp 0/0", bus.s_addr, bus.s_wr_data); end
        bus.master_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack || bus.s_wr_en) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_strobe: got %0d exp 0", seen); end
        run_frame(1'b1, 12'h001, 8'hFF, '0, -1, 0, 1'b0, -1);
        vectors++; if (addr_at_ack !== 12'h001 || wdat_at_ack !== 8'hFF) begin
            miscompares++; $display("FAIL abort_next_regs: got %h/%h exp 001/ff", addr_at_ack, wdat_at_ack); end
        vectors++; if (wr_en_cyc !== 20 || ack_cyc !== 21) begin miscompares++; $display("FAIL abort_next_timing: got %0d/%0d exp 20/21", wr_en_cyc, ack_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic e, o;
        run_frame(1'b1, 12'h5A5, 8'h3C, '0, -1, 0, 1'b0, -1);
        vectors++; if (ack_cyc !== 21 || wdat_at_ack !== 8'h3C || addr_at_ack !== 12'h5A5) begin
            miscompares++; $display("FAIL b2b_wr: got ack %0d %h/%h exp 21 5a5/3c", ack_cyc, addr_at_ack, wdat_at_ack); end
        d = 8'hC3;
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        run_frame(1'b0, 12'h0F0, '0, d, -1, 0, 1'b0, -1);
        vectors++; if (rdy0 !== 1'b1 || rd_en_cyc !== 12) begin miscompares++; $display("FAIL b2b_start: got rdy %b rd_en %0d exp 1/12", rdy0, rd_en_cyc); end
        vectors++; if (ack_cyc !== 24 || addr_at_ack !== 12'h0F0 || wdat_at_ack !== 8'h3C) begin
            miscompares++; $display("FAIL b2b_rd: got ack %0d %h/%h exp 24 0f0/3c", ack_cyc, addr_at_ack, wdat_at_ack); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_bit%0d: got %b exp %b", i, o, e); end
        end
    endtask

    initial begin
        bus.mode = 1'b0; bus.wr_bus = 1'b0; bus.master_valid = 1'b0; bus.master_ready = 1'b0;
        bus.s_rd_data = '0; bus.s_rd_valid = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_ready_toggle();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
